// File: rtl/apu_tnd_sampler_pkg.sv
// Shared constants and helpers for the triangle/noise/DMC sampler:
// mix weights, data widths and the DC-blocker saturation helper.
package apu_tnd_sampler_pkg;

   localparam int TRI_W    = 3;
   localparam int RND_W    = 2;
   localparam int DMC_W    = 1;
   localparam int MIX_W    = 8;
   localparam int SAMPLE_W = 16;
   localparam int DC_SHIFT = 8;

   // Linear mix; the weights keep the worst case (202) inside 8 bits.
   function automatic logic [MIX_W-1:0] mix_level(input logic [3:0] tri_l,
                                                  input logic [3:0] rnd_l,
                                                  input logic [6:0] dmc_l);
      return MIX_W'(tri_l) * MIX_W'(TRI_W) +
             MIX_W'(rnd_l) * MIX_W'(RND_W) +
             MIX_W'(dmc_l) * MIX_W'(DMC_W);
   endfunction

   function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [18:0] v);
      if (v > 19'sd32767)       return 16'sh7fff;
      else if (v < -19'sd32768) return 16'sh8000;
      else                      return v[SAMPLE_W-1:0];
   endfunction

endpackage

// File: rtl/apu_tnd_sampler_fifo.sv
// First-word-fall-through sample FIFO; pointers carry one extra wrap bit
// so full/empty fall out of a plain compare.
module apu_sample_fifo
   import apu_tnd_sampler_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = SAMPLE_W
) (
   input  logic                     CLK,
   input  logic                     n_RES,
   input  logic                     push,
   input  logic [W-1:0]             din,
   input  logic                     pop,
   output logic [W-1:0]             dout,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW:0]   wr_q, rd_q;
   logic [W-1:0]  hold_q;
   logic          pop_ok, push_ok;

   assign empty   = (wr_q == rd_q);
   assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign level   = wr_q - rd_q;
   // Pop frees a slot before push looks at full.
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign dout    = empty ? hold_q : mem_q[rd_q[AW-1:0]];

   always_ff @(posedge CLK or negedge n_RES) begin
      if (!n_RES) begin
         wr_q   <= '0;
         rd_q   <= '0;
         hold_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         if (pop_ok) begin
            rd_q   <= rd_q + 1'b1;
            hold_q <= mem_q[rd_q[AW-1:0]];
         end
         if (push_ok) begin
            mem_q[wr_q[AW-1:0]] <= din;
            wr_q                <= wr_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/apu_tnd_sampler.sv
// Mixes TRI/RND/DMC levels, box-car decimates per ACLK strobe into 16-bit PCM
// and queues samples for a valid/ready sink. Optional APU_SAMPLER_DC_BLOCK_EN adds a DC blocker.
module apu_tnd_sampler
   import apu_tnd_sampler_pkg::*;
#(
   parameter int DECIM_LOG2 = 5,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                           CLK,
   input  logic                           n_RES,
   input  logic                           ACLK_en,
   input  logic [3:0]                     TRI_Out,
   input  logic [3:0]                     RND_Out,
   input  logic [6:0]                     DMC_Out,
   input  logic                           MUTE,
   output logic [SAMPLE_W-1:0]            S_DATA,
   output logic                           S_VALID,
   input  logic                           S_READY,
   output logic                           OVF,
   input  logic                           OVF_CLR,
   output logic [$clog2(FIFO_DEPTH):0]    FIFO_LEVEL
);
   localparam int ACC_W = MIX_W + DECIM_LOG2;

   logic [MIX_W-1:0]      mix;
   logic [ACC_W-1:0]      acc_q, acc_d, sum;
   logic [DECIM_LOG2-1:0] cnt_q, cnt_d;
   logic                  win_push;
   logic [SAMPLE_W-1:0]   sample;
   logic                  fifo_push, fifo_empty, fifo_full;
   logic [SAMPLE_W-1:0]   fifo_din;
   logic                  ovf_q, ovf_d, drop;

   assign mix    = MUTE ? '0 : mix_level(TRI_Out, RND_Out, DMC_Out);
   assign sum    = acc_q + ACC_W'(mix);
   assign sample = SAMPLE_W'(sum) << (MIX_W - DECIM_LOG2);

   always_comb begin
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      win_push = 1'b0;
      if (ACLK_en) begin
         if (cnt_q == '1) begin
            acc_d    = '0;
            cnt_d    = '0;
            win_push = 1'b1;
         end else begin
            acc_d = sum;
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge n_RES) begin
      if (!n_RES) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
      end
   end

`ifdef APU_SAMPLER_DC_BLOCK_EN
   // One-pole high-pass; its output is registered, costing one extra CLK.
   logic [SAMPLE_W-1:0]        x_prev_q, x_cur;
   logic signed [SAMPLE_W-1:0] y_prev_q, y_cur;
   logic signed [18:0]         xe, xpe, ype, ysum;
   logic                       fpush_q;
   logic [SAMPLE_W-1:0]        fdata_q;

   assign x_cur = {1'b0, sample[SAMPLE_W-1:1]};
   assign xe    = {3'b000, x_cur};
   assign xpe   = {3'b000, x_prev_q};
   assign ype   = {{3{y_prev_q[SAMPLE_W-1]}}, y_prev_q};
   assign ysum  = xe - xpe + ype - (ype >>> DC_SHIFT);
   assign y_cur = sat16(ysum);

   always_ff @(posedge CLK or negedge n_RES) begin
      if (!n_RES) begin
         x_prev_q <= '0;
         y_prev_q <= '0;
         fpush_q  <= 1'b0;
         fdata_q  <= '0;
      end else begin
         fpush_q <= win_push;
         if (win_push) begin
            x_prev_q <= x_cur;
            y_prev_q <= y_cur;
            fdata_q  <= y_cur;
         end
      end
   end

   assign fifo_push = fpush_q;
   assign fifo_din  = fdata_q;
`else
   assign fifo_push = win_push;
   assign fifo_din  = sample;
`endif

   apu_sample_fifo #(.DEPTH(FIFO_DEPTH), .W(SAMPLE_W)) u_fifo (
      .CLK   (CLK),
      .n_RES (n_RES),
      .push  (fifo_push),
      .din   (fifo_din),
      .pop   (S_READY),
      .dout  (S_DATA),
      .empty (fifo_empty),
      .full  (fifo_full),
      .level (FIFO_LEVEL)
   );

   // A simultaneous pop makes room, so only a pop-less push into full drops.
   assign drop  = fifo_push & fifo_full & ~(S_READY & ~fifo_empty);
   assign ovf_d = drop ? 1'b1 : (OVF_CLR ? 1'b0 : ovf_q);

   always_ff @(posedge CLK or negedge n_RES) begin
      if (!n_RES) ovf_q <= 1'b0;
      else        ovf_q <= ovf_d;
   end

   assign OVF     = ovf_q;
   assign S_VALID = ~fifo_empty;

endmodule
